rom_burst_reader: RTL
=====================

// Module: rom_burst_reader
// PURPOSE
//  Upstream address sequencer for the registered lookup ROM (5-bit addr, 8-bit data, 2-cycle addr->data).
//  - Accepts a burst request (start address, length) and issues sequential ROM addresses.
//  - Tracks ROM read latency and buffers returned words in a small FIFO.
//  - Presents data on a valid/ready stream with last-beat marking, so downstream backpressure never loses a word.
// PARAMETERS
//  ADDR_W      5   ROM address width
//  DATA_W      8   ROM data width
//  ROM_LAT     2   cycles from rom_addr change to matching rom_data (ROM address register + output register)
//  FIFO_DEPTH  4   output buffer entries, power of 2, >= ROM_LAT+1
// PORTS
//  clock       in   1         single clock, rising edge
//  reset       in   1         asynchronous, active-high; clears all state
//  start       in   1         burst request, sampled only in IDLE
//  start_addr  in   ADDR_W    first ROM address of burst
//  burst_len   in   ADDR_W+1  words to read, 1..2^ADDR_W; 0 = empty burst
//  busy        out  1         high from accepted start until done
//  done        out  1         one-cycle pulse when burst completes
//  rom_addr    out  ADDR_W    drives ROM addr input (registered)
//  rom_data    in   DATA_W    ROM dataout
//  m_valid     out  1         output word valid
//  m_ready     in   1         downstream accepts word
//  m_data      out  DATA_W    output word
//  m_last      out  1         qualifies final word of burst
// BEHAVIOUR
//  Reset values: busy=0, done=0, rom_addr=0, m_valid=0, m_data=0, m_last=0, FIFO empty, tag pipe cleared.
//  FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//   - IDLE, start=1, burst_len!=0: latch addr/len, busy=1, -> ISSUE.
//   - IDLE, start=1, burst_len=0: done pulses next cycle, busy stays 0, no ROM access.
//   - ISSUE: when in_flight + fifo_count < FIFO_DEPTH, register next address onto rom_addr.
//     Push a tag (valid, last) into the ROM_LAT-deep tag shift register, then decrement remaining.
//     After the final issue -> DRAIN.
//   - DRAIN: when tag pipe is empty, FIFO is empty and last beat is accepted: done=1 for one cycle, busy=0, -> IDLE.
//  start while busy is ignored.
//  Latency: the first rom_addr is registered on the edge that accepts start (E).
//   - rom_data is valid after edge E+ROM_LAT; it is written to the FIFO at E+ROM_LAT+1.
//   - First m_valid is at E+3 with defaults.
//   - One word per cycle is sustained while m_ready=1.
//  Address arithmetic: increment modulo 2^ADDR_W (31 -> 0 wraps, no error).
//  Credit rule guarantees no FIFO overflow: words already in the ROM pipe always have an entry reserved.
//  Stream: m_data/m_last are held stable while m_valid=1 and m_ready=0. A beat transfers when m_valid & m_ready.
//  FIFO push and pop in the same cycle are both honoured; count is unchanged.
//  m_last is set only on the word tagged last; done follows the m_last transfer by one cycle.
//  rom_addr holds its last value when not issuing.
//  The ROM has no reset, so its output after reset is ignored; only tagged words enter the FIFO.
//  Reset mid-burst aborts immediately: in-flight words are discarded, FSM returns to IDLE, no done pulse.
// TESTING
//  - Reset, then start_addr=0, burst_len=3, m_ready=1 -> m_data 8'h83, 8'h05, 8'h09 on consecutive cycles.
//    First beat at E+3; m_last on 8'h09; done on the next cycle.
//  - Wrap: start_addr=30, burst_len=4 -> 8'hE5, 8'h7E, 8'h83, 8'h05; rom_addr sequence 30, 31, 0, 1.
//  - Backpressure: burst 0..7, m_ready held 0 for 10 cycles.
//    Expect at most FIFO_DEPTH words buffered, issue stalls, m_data holds 8'h83.
//    On release, all 8 words arrive in order with none lost.
//  - Full burst: start_addr=5, burst_len=32, m_ready toggling 1/0 -> 32 words in order.
//    Expect exactly one m_last (addr 4 -> 8'h11) and exactly one done.
//  - burst_len=0 -> done pulse, busy never 1, rom_addr unchanged. A start while busy is ignored with no extra words.
//  - Assert reset mid-burst after 2 beats -> all outputs at reset values next cycle.
//    A new burst afterwards returns correct data with no stale words.

Source files
------------

// File: rtl/rom_burst_reader_if.sv
// Bus bundle for the ROM burst reader: burst request/status, ROM address/data,
// and the valid/ready output stream.
interface rom_burst_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   burst_len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   // The reader itself
   modport master (
      input  start, start_addr, burst_len, rom_data, m_ready,
      output busy, done, rom_addr, m_valid, m_data, m_last
   );

   // The environment: requester, ROM and downstream consumer
   modport slave (
      output start, start_addr, burst_len, rom_data, m_ready,
      input  busy, done, rom_addr, m_valid, m_data, m_last
   );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst address sequencer for a registered ROM. Issues sequential addresses,
// tracks the ROM read latency with a tag pipe, and buffers returned words in
// a small FIFO so downstream backpressure never drops data. Issue is gated by
// a credit rule: words in the ROM pipe plus words in the FIFO never exceed
// FIFO_DEPTH, so every word in flight has a FIFO entry reserved.
module rom_burst_reader #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int ROM_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   rom_burst_reader_if.master bus
);
   localparam int LEN_W = ADDR_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + ROM_LAT + 2) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic              done_q, done_d;
   // Tag slot 0 travels with rom_addr; slot ROM_LAT lines up with rom_data.
   logic [ROM_LAT:0]  tag_vld_q, tag_vld_d;
   logic [ROM_LAT:0]  tag_last_q, tag_last_d;
   logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];
   logic [DATA_W:0]   fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

   logic              issue, issue_last;
   logic              push, pop, m_valid, head_last;
   logic [DATA_W:0]   head;
   logic [OCC_W-1:0]  in_flight, occ;
   logic              credit_ok;

   assign m_valid   = (fifo_cnt_q != '0);
   assign head      = fifo_mem_q[rd_ptr_q];
   assign head_last = m_valid & head[DATA_W];
   assign pop       = m_valid & bus.m_ready;
   assign push      = tag_vld_q[ROM_LAT];

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.m_valid  = m_valid;
   assign bus.m_data   = m_valid ? head[DATA_W-1:0] : '0;
   assign bus.m_last   = head_last;

   // Credit check: reserved entries (ROM pipe + FIFO, minus the word leaving now)
   always_comb begin
      in_flight = '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
         in_flight = in_flight + OCC_W'(tag_vld_q[i]);
      end
      occ       = in_flight + OCC_W'(fifo_cnt_q) - OCC_W'(pop);
      credit_ok = (occ < OCC_W'(FIFO_DEPTH));
   end

   // Burst FSM: next state, address issue and done pulse
   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      rom_addr_d  = rom_addr_q;
      remain_d    = remain_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      issue_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  // FIFO and tag pipe are empty in IDLE, so the first issue needs no credit check
                  issue       = 1'b1;
                  issue_last  = (bus.burst_len == LEN_W'(1));
                  rom_addr_d  = bus.start_addr;
                  next_addr_d = bus.start_addr + ADDR_W'(1);
                  remain_d    = bus.burst_len - LEN_W'(1);
                  state_d     = issue_last ? S_DRAIN : S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (credit_ok) begin
               issue       = 1'b1;
               issue_last  = (remain_q == LEN_W'(1));
               rom_addr_d  = next_addr_q;
               next_addr_d = next_addr_q + ADDR_W'(1);
               remain_d    = remain_q - LEN_W'(1);
               if (issue_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The last-tagged word leaving means pipe and FIFO are both empty
            if (pop && head_last) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Tag pipe shift and FIFO push/pop bookkeeping
   always_comb begin
      tag_vld_d  = {tag_vld_q[ROM_LAT-1:0], issue};
      tag_last_d = {tag_last_q[ROM_LAT-1:0], issue_last};
      fifo_mem_d = fifo_mem_q;
      if (push) fifo_mem_d[wr_ptr_q] = {tag_last_q[ROM_LAT], bus.rom_data};
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers; reset aborts any burst and discards in-flight words
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         next_addr_q <= '0;
         rom_addr_q  <= '0;
         remain_q    <= '0;
         done_q      <= 1'b0;
         tag_vld_q   <= '0;
         tag_last_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         rom_addr_q  <= rom_addr_d;
         remain_q    <= remain_d;
         done_q      <= done_d;
         tag_vld_q   <= tag_vld_d;
         tag_last_q  <= tag_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         fifo_mem_q  <= fifo_mem_d;
      end
   end
endmodule
